// File: rtl/cpu_txn_gen_pkg.sv
// Shared types and constants for the CPU transaction generator.
// A table entry is packed as {addr, data, wr, chk}, LSB = chk.
package cpu_txn_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam int ERR_CNT_W     = 8;
  localparam int ENTRY_CTL_W   = 2;
  localparam int ENTRY_WR_BIT  = 1;
  localparam int ENTRY_CHK_BIT = 0;

  function automatic int entry_w(input int addr_w, input int data_w);
    return addr_w + data_w + ENTRY_CTL_W;
  endfunction

  // Table index increment that wraps for non-power-of-two depths.
  function automatic int wrap_inc(input int i, input int depth);
    return (i >= depth - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/trig_sync_edge.sv
// Two-flop synchroniser for an asynchronous pushbutton plus a one-cycle
// pulse on each rising edge of the synchronised level.
module trig_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic trig_r
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], trig};
  end

  assign trig_r = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/cpu_txn_gen_p.sv
// Programmable CPU transaction generator: replays a loadable table toward the
// cache controller, one entry per trigger or back-to-back in run mode.
//
// state | meaning
// IDLE  | waiting for trigger or run mode; table load allowed
// FETCH | advance idx to the next entry
// ISSUE | cs high until rdy (after min hold) or timeout
// CHECK | compare captured read data, update status
module cpu_txn_gen_p
  import cpu_txn_gen_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int CS_HOLD  = 4,
  parameter int TIMEOUT  = 255,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trig,
  input  logic                 run_mode,
  input  logic                 ld_en,
  input  logic [IDX_W-1:0]     ld_idx,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 ld_wr,
  input  logic                 ld_chk,
  input  logic                 rdy,
  input  logic [DATA_W-1:0]    din,
  input  logic                 clr,
  output logic [ADDR_W-1:0]    Address,
  output logic [DATA_W-1:0]    DOut,
  output logic                 wr_rd,
  output logic                 cs,
  output logic                 busy,
  output logic [IDX_W-1:0]     idx,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 tmo
);

  localparam int ENTRY_W  = entry_w(ADDR_W, DATA_W);
  localparam int HOLD_MAX = (CS_HOLD > TIMEOUT) ? CS_HOLD : TIMEOUT;
  localparam int HC_W     = $clog2(HOLD_MAX + 1);

  state_t             state, state_nxt;
  logic               trig_r;
  logic [ENTRY_W-1:0] tbl [DEPTH];
  logic [ENTRY_W-1:0] cur;
  logic               cur_chk;
  logic [HC_W-1:0]    hold_cnt;
  logic [DATA_W-1:0]  rd_q;
  logic               tmo_now;
  logic               hold_ok, tmo_hit, rdy_ok;

  trig_sync_edge u_trig (
    .clk    (clk),
    .rst    (rst),
    .trig   (trig),
    .trig_r (trig_r)
  );

  assign cur     = tbl[idx];
  assign Address = cur[ENTRY_W-1 -: ADDR_W];
  assign DOut    = cur[ENTRY_CTL_W +: DATA_W];
  assign wr_rd   = cur[ENTRY_WR_BIT];
  assign cur_chk = cur[ENTRY_CHK_BIT];

  assign hold_ok = (hold_cnt >= HC_W'(CS_HOLD - 1));
  assign tmo_hit = (TIMEOUT != 0) && (hold_cnt >= HC_W'(TIMEOUT - 1));
  assign rdy_ok  = hold_ok && rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run_mode || trig_r) state_nxt = FETCH;
      FETCH:   state_nxt = ISSUE;
      ISSUE:   if (rdy_ok || tmo_hit) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cs   = (state == ISSUE);
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (ld_en && (state == IDLE) && (int'(ld_idx) < DEPTH)) begin
      tbl[ld_idx] <= {ld_addr, ld_data, ld_wr, ld_chk};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= IDX_W'(DEPTH - 1);
      hold_cnt <= '0;
      rd_q     <= '0;
      tmo_now  <= 1'b0;
    end else begin
      if (state == FETCH) idx <= IDX_W'(wrap_inc(int'(idx), DEPTH));
      if (state == ISSUE) begin
        if (hold_cnt != '1) hold_cnt <= hold_cnt + HC_W'(1);
        tmo_now <= tmo_hit && !rdy_ok;
        if (rdy_ok) rd_q <= din;
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  // clr wins over a same-cycle set or increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
      tmo     <= 1'b0;
    end else if (clr) begin
      err     <= 1'b0;
      err_cnt <= '0;
      tmo     <= 1'b0;
    end else begin
      if ((state == ISSUE) && tmo_hit && !rdy_ok) tmo <= 1'b1;
      if ((state == CHECK) && !wr_rd && cur_chk && !tmo_now && (rd_q != DOut)) begin
        err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_txn_gen_p.sv
// Bench for cpu_txn_gen_p: two instances (DEPTH=8/TIMEOUT=255 and DEPTH=5/TIMEOUT=8)
// share stimulus; a transaction-level model feeds per-instance expectation queues.
module tb_cpu_txn_gen_p;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int IW  = 3;
  localparam int CSH = 4;

  typedef struct {
    int idx; int addr; int data; int wr; int len; int gap; int err; int cnt; int tmo;
  } txn_t;

  logic          clk, rst, trig, run_mode, ld_en, ld_wr, ld_chk, clr;
  logic [IW-1:0] ld_idx;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data, din;
  logic          rdy_a, rdy_b;

  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] dout_a, dout_b;
  logic          wr_a, wr_b, cs_a, cs_b, busy_a, busy_b, err_a, err_b, tmo_a, tmo_b;
  logic [IW-1:0] idx_a, idx_b;
  logic [7:0]    cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;
  int rdy_dly = 0;
  int cyc = 0;

  txn_t q0[$];
  txn_t q1[$];

  int m_addr[2][8], m_data[2][8], m_wr[2][8], m_chk[2][8];
  int m_idx[2], m_err[2], m_cnt[2], m_tmo[2];

  int   phase[2], len[2], rise_cnt[2], last_rise[2];
  bit   cs_prev[2];
  txn_t cur[2];
  int   k_a, k_b;

  int s_cs[2], s_busy[2], s_idx[2], s_addr[2], s_dout[2], s_wr[2], s_err[2], s_cnt[2], s_tmo[2];

  cpu_txn_gen_p #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(8), .CS_HOLD(CSH), .TIMEOUT(255)) u_a (
    .clk(clk), .rst(rst), .trig(trig), .run_mode(run_mode), .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_wr(ld_wr), .ld_chk(ld_chk), .rdy(rdy_a),
    .din(din), .clr(clr), .Address(addr_a), .DOut(dout_a), .wr_rd(wr_a), .cs(cs_a),
    .busy(busy_a), .idx(idx_a), .err(err_a), .err_cnt(cnt_a), .tmo(tmo_a));

  cpu_txn_gen_p #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(5), .CS_HOLD(CSH), .TIMEOUT(8)) u_b (
    .clk(clk), .rst(rst), .trig(trig), .run_mode(run_mode), .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_wr(ld_wr), .ld_chk(ld_chk), .rdy(rdy_b),
    .din(din), .clr(clr), .Address(addr_b), .DOut(dout_b), .wr_rd(wr_b), .cs(cs_b),
    .busy(busy_b), .idx(idx_b), .err(err_b), .err_cnt(cnt_b), .tmo(tmo_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep_of(input int d);
    return (d == 0) ? 8 : 5;
  endfunction

  function automatic int tmo_of(input int d);
    return (d == 0) ? 255 : 8;
  endfunction

  task automatic chk(input string nm, input int d, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s[dut%0d] got 0x%0h expected 0x%0h at t=%0t", nm, d, act, expv, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic txn_t qpop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Responder: rdy rises once cs has been high for rdy_dly cycles.
  always @(negedge clk) begin
    if (cs_a) begin rdy_a = (k_a >= rdy_dly); k_a++; end
    else begin rdy_a = 1'b0; k_a = 0; end
    if (cs_b) begin rdy_b = (k_b >= rdy_dly); k_b++; end
    else begin rdy_b = 1'b0; k_b = 0; end
  end

  // Monitor: pops an expectation at each cs rise, then checks hold length and status.
  always @(negedge clk) begin
    cyc++;
    s_cs[0] = int'(cs_a);     s_cs[1] = int'(cs_b);
    s_busy[0] = int'(busy_a); s_busy[1] = int'(busy_b);
    s_idx[0] = int'(idx_a);   s_idx[1] = int'(idx_b);
    s_addr[0] = int'(addr_a); s_addr[1] = int'(addr_b);
    s_dout[0] = int'(dout_a); s_dout[1] = int'(dout_b);
    s_wr[0] = int'(wr_a);     s_wr[1] = int'(wr_b);
    s_err[0] = int'(err_a);   s_err[1] = int'(err_b);
    s_cnt[0] = int'(cnt_a);   s_cnt[1] = int'(cnt_b);
    s_tmo[0] = int'(tmo_a);   s_tmo[1] = int'(tmo_b);
    if (rst) begin
      q0.delete();
      q1.delete();
      for (int d = 0; d < 2; d++) begin phase[d] = 0; cs_prev[d] = 1'b0; end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (s_cs[d] != 0 && !cs_prev[d]) begin
          rise_cnt[d]++;
          if (qsize(d) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn[dut%0d] got cs rise with idx %0d expected none at t=%0t", d, s_idx[d], $time);
            phase[d] = 0;
          end else begin
            cur[d] = qpop(d);
            chk("idx", d, s_idx[d], cur[d].idx);
            chk("addr", d, s_addr[d], cur[d].addr);
            chk("dout", d, s_dout[d], cur[d].data);
            chk("wr_rd", d, s_wr[d], cur[d].wr);
            if (cur[d].gap != 0) chk("rise_gap", d, cyc - last_rise[d], cur[d].gap);
            phase[d] = 1;
            len[d] = 1;
          end
          last_rise[d] = cyc;
        end else if (s_cs[d] != 0 && phase[d] == 1) begin
          len[d]++;
          chk("addr_stable", d, s_addr[d], cur[d].addr);
          chk("dout_stable", d, s_dout[d], cur[d].data);
        end else if (s_cs[d] == 0 && cs_prev[d] && phase[d] == 1) begin
          chk("cs_len", d, len[d], cur[d].len);
          chk("busy_check", d, s_busy[d], 1);
          phase[d] = 2;
        end else if (phase[d] == 2) begin
          chk("busy_idle", d, s_busy[d], 0);
          chk("err", d, s_err[d], cur[d].err);
          chk("err_cnt", d, s_cnt[d], cur[d].cnt);
          chk("tmo", d, s_tmo[d], cur[d].tmo);
          phase[d] = 0;
        end
        cs_prev[d] = (s_cs[d] != 0);
      end
    end
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        m_addr[d][i] = 0; m_data[d][i] = 0; m_wr[d][i] = 0; m_chk[d][i] = 0;
      end
      m_idx[d] = dep_of(d) - 1;
      m_err[d] = 0; m_cnt[d] = 0; m_tmo[d] = 0;
    end
  endtask

  // Predict one transaction for DUT d from the table, rdy delay and current din.
  task automatic expect_txn(input int d, input int gap);
    txn_t t;
    int h, to, timed_out;
    m_idx[d] = (m_idx[d] + 1) % dep_of(d);
    h = (rdy_dly > CSH - 1) ? rdy_dly : CSH - 1;
    to = tmo_of(d);
    timed_out = (to != 0 && to - 1 < h) ? 1 : 0;
    t.len = timed_out ? to : h + 1;
    if (timed_out) m_tmo[d] = 1;
    if (!timed_out && m_wr[d][m_idx[d]] == 0 && m_chk[d][m_idx[d]] == 1 && int'(din) != m_data[d][m_idx[d]]) begin
      m_err[d] = 1;
      if (m_cnt[d] < 255) m_cnt[d]++;
    end
    t.idx = m_idx[d];
    t.addr = m_addr[d][m_idx[d]];
    t.data = m_data[d][m_idx[d]];
    t.wr = m_wr[d][m_idx[d]];
    t.gap = gap;
    t.err = m_err[d];
    t.cnt = m_cnt[d];
    t.tmo = m_tmo[d];
    if (d == 0) q0.push_back(t);
    else q1.push_back(t);
  endtask

  task automatic drive_load(input int i, input int a, input int dt, input int w, input int c);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = IW'(i); ld_addr = AW'(a); ld_data = DW'(dt); ld_wr = w[0]; ld_chk = c[0];
    @(negedge clk);
    ld_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (i < dep_of(d)) begin
        m_addr[d][i] = a; m_data[d][i] = dt; m_wr[d][i] = w; m_chk[d][i] = c;
      end
    end
  endtask

  task automatic pulse_trig();
    @(posedge clk);
    #($urandom_range(1, 8));
    trig = 1'b1;
    repeat (3) @(posedge clk);
    #2 trig = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (q0.size() == 0 && q1.size() == 0 && phase[0] == 0 && phase[1] == 0 && !busy_a && !busy_b) break;
      n++;
      if (n > budget) begin
        checks++;
        errors++;
        $display("FAIL wait_done timeout: got busy after %0d cycles expected idle", budget);
        break;
      end
    end
  endtask

  task automatic wait_cs(input int budget);
    int n;
    n = 0;
    while (!cs_a) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        checks++;
        errors++;
        $display("FAIL wait_cs timeout: got cs=0 after %0d cycles expected cs=1", budget);
        break;
      end
    end
  endtask

  task automatic step(input int dly, input int dv);
    rdy_dly = dly;
    din = DW'(dv);
    expect_txn(0, 0);
    expect_txn(1, 0);
    pulse_trig();
    wait_done(300);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int d = 0; d < 2; d++) begin m_err[d] = 0; m_cnt[d] = 0; m_tmo[d] = 0; end
    #1;
    chk("clr_err", 0, int'(err_a), 0);
    chk("clr_cnt", 0, int'(cnt_a), 0);
    chk("clr_tmo", 0, int'(tmo_a), 0);
    chk("clr_err", 1, int'(err_b), 0);
    chk("clr_cnt", 1, int'(cnt_b), 0);
    chk("clr_tmo", 1, int'(tmo_b), 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_cs", 0, int'(cs_a), 0);       chk("rst_cs", 1, int'(cs_b), 0);
    chk("rst_busy", 0, int'(busy_a), 0);   chk("rst_busy", 1, int'(busy_b), 0);
    chk("rst_idx", 0, int'(idx_a), 7);     chk("rst_idx", 1, int'(idx_b), 4);
    chk("rst_addr", 0, int'(addr_a), 0);   chk("rst_addr", 1, int'(addr_b), 0);
    chk("rst_dout", 0, int'(dout_a), 0);   chk("rst_dout", 1, int'(dout_b), 0);
    chk("rst_wr", 0, int'(wr_a), 0);       chk("rst_wr", 1, int'(wr_b), 0);
    chk("rst_err", 0, int'(err_a), 0);     chk("rst_err", 1, int'(err_b), 0);
    chk("rst_cnt", 0, int'(cnt_a), 0);     chk("rst_cnt", 1, int'(cnt_b), 0);
    chk("rst_tmo", 0, int'(tmo_a), 0);     chk("rst_tmo", 1, int'(tmo_b), 0);
  endtask

  // Run mode for n transactions, dropping run_mode during the last ISSUE.
  task automatic run_burst(input int n);
    int base, w;
    rdy_dly = 0;
    for (int i = 0; i < n; i++) begin
      expect_txn(0, (i == 0) ? 0 : 7);
      expect_txn(1, (i == 0) ? 0 : 7);
    end
    base = rise_cnt[0];
    @(negedge clk);
    run_mode = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rise_cnt[0] >= base + n) break;
      w++;
      if (w > n * 7 + 50) begin
        checks++;
        errors++;
        $display("FAIL run_burst timeout: got %0d rises expected %0d", rise_cnt[0] - base, n);
        break;
      end
    end
    run_mode = 1'b0;
    wait_done(100);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by t=%0t expected completion", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_a, base_b;
    rst = 1'b1; trig = 1'b0; run_mode = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_addr = '0;
    ld_data = '0; ld_wr = 1'b0; ld_chk = 1'b0; din = '0; clr = 1'b0;
    rdy_a = 1'b0; rdy_b = 1'b0; k_a = 0; k_b = 0;
    for (int d = 0; d < 2; d++) begin phase[d] = 0; len[d] = 0; rise_cnt[d] = 0; last_rise[d] = 0; cs_prev[d] = 1'b0; end
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals();

    drive_load(0, 'h1100, 'hAA, 1, 0);
    step(0, $urandom_range(0, 255));

    drive_load(1, 'h3346, 'h5A, 0, 1);
    drive_load(2, 'h3346, 'h5A, 0, 1);
    step(0, 'h5A);
    step(0, 'h00);
    do_clr();

    drive_load(3, 'h0ACE, 'h11, 0, 1);
    step(10, 'h22);
    step(7, 'h11);
    step(1, 'h33);
    do_clr();

    for (int i = 0; i < 14; i++) begin
      int e, nx, dv;
      e = $urandom_range(0, 4);
      drive_load(e, $urandom_range(0, 65535), $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1));
      nx = (m_idx[0] + 1) % 8;
      dv = ($urandom_range(0, 1) == 1) ? m_data[0][nx] : $urandom_range(0, 255);
      step($urandom_range(0, 12), dv);
    end

    // Load attempts during ISSUE must not alter the table.
    rdy_dly = 6;
    expect_txn(0, 0);
    expect_txn(1, 0);
    pulse_trig();
    wait_cs(50);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = IW'(m_idx[0]); ld_addr = 16'hDEAD; ld_data = 8'hBE; ld_wr = ~ld_wr; ld_chk = 1'b1;
    @(negedge clk);
    ld_idx = IW'(m_idx[1]);
    @(negedge clk);
    ld_en = 1'b0;
    wait_done(300);
    chk("tbl_hold_addr", 0, int'(addr_a), m_addr[0][m_idx[0]]);
    chk("tbl_hold_data", 0, int'(dout_a), m_data[0][m_idx[0]]);
    chk("tbl_hold_addr", 1, int'(addr_b), m_addr[1][m_idx[1]]);
    chk("tbl_hold_data", 1, int'(dout_b), m_data[1][m_idx[1]]);

    // Second trigger edge while busy is dropped.
    base_a = rise_cnt[0];
    base_b = rise_cnt[1];
    rdy_dly = 0;
    din = 8'h00;
    expect_txn(0, 0);
    expect_txn(1, 0);
    @(posedge clk);
    #3 trig = 1'b1;
    repeat (3) @(posedge clk);
    #1 trig = 1'b0;
    repeat (2) @(posedge clk);
    #1 trig = 1'b1;
    repeat (3) @(posedge clk);
    #1 trig = 1'b0;
    wait_done(100);
    repeat (20) @(negedge clk);
    chk("single_txn", 0, rise_cnt[0] - base_a, 1);
    chk("single_txn", 1, rise_cnt[1] - base_b, 1);

    // Reset in the middle of ISSUE.
    rdy_dly = 20;
    expect_txn(0, 0);
    expect_txn(1, 0);
    pulse_trig();
    wait_cs(50);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();

    run_burst(10);

    for (int i = 0; i < 8; i++) drive_load(i, 'h2000 + i, 'h5A, 0, 1);
    din = 8'h00;
    run_burst(260);
    chk("cnt_sat", 0, int'(cnt_a), 255);
    chk("cnt_sat", 1, int'(cnt_b), 255);
    do_clr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
